// File: rtl/pd_seq_ctrl.sv
// Power-domain sequencer: ordered clock/isolation/retention/reset/power control for one gated domain.
// Optional ack timeout (sticky o_err) is built when PD_SEQ_ACK_TIMEOUT_EN is defined.
module pd_seq_ctrl (
    input  logic       i_aon_clk,
    input  logic       i_soc_pwr_on_rst_n,
    input  logic       i_sw_sleep_req,
    input  logic       i_wakeup,
    input  logic       i_hw_sleep_ack,
    input  logic       i_pwr_on_ack,
    input  logic [3:0] i_pwr_off_seq_delay,
    input  logic [3:0] i_pwr_on_seq_delay,
    input  logic       i_ret_en,
    output logic       o_sleep_req,
    output logic       o_pwr_on_req,
    output logic       o_clk_en,
    output logic       o_iso,
    output logic       o_ret,
    output logic       o_rstn,
    output logic [3:0] o_state,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [3:0] ST_ON      = 4'd0;
    localparam logic [3:0] ST_SLP_REQ = 4'd1;
    localparam logic [3:0] ST_CLK_OFF = 4'd2;
    localparam logic [3:0] ST_ISO_ON  = 4'd3;
    localparam logic [3:0] ST_RET_ON  = 4'd4;
    localparam logic [3:0] ST_RST_ON  = 4'd5;
    localparam logic [3:0] ST_PWR_OFF = 4'd6;
    localparam logic [3:0] ST_OFF     = 4'd7;
    localparam logic [3:0] ST_PWR_ON  = 4'd8;
    localparam logic [3:0] ST_RST_OFF = 4'd9;
    localparam logic [3:0] ST_RET_OFF = 4'd10;
    localparam logic [3:0] ST_ISO_OFF = 4'd11;
    localparam logic [3:0] ST_CLK_ON  = 4'd12;

    logic [3:0] state;
    logic [3:0] state_nx;
    logic [3:0] cnt;
    logic [3:0] dly;
    logic [3:0] d_m1;
    logic       timed;
    logic       step_done;
    logic       ack_seen;
    logic       waiting;
    logic       tmo;
    logic       wake_pend;
    logic       ret_flag;

    // Timed steps last max(delay,1) cycles; the delay is re-read every cycle for the exit compare.
    always_comb begin
        timed = 1'b0;
        case (state)
            ST_CLK_OFF, ST_ISO_ON, ST_RET_ON, ST_RST_ON,
            ST_RST_OFF, ST_RET_OFF, ST_ISO_OFF, ST_CLK_ON: timed = 1'b1;
            default: timed = 1'b0;
        endcase
        dly       = (state >= ST_RST_OFF) ? i_pwr_on_seq_delay : i_pwr_off_seq_delay;
        d_m1      = (dly == 4'd0) ? 4'd0 : dly - 4'd1;
        step_done = timed && (cnt == d_m1);
    end

    always_comb begin
        ack_seen = 1'b0;
        waiting  = 1'b0;
        case (state)
            ST_SLP_REQ: begin ack_seen = i_hw_sleep_ack; waiting = 1'b1; end
            ST_PWR_OFF: begin ack_seen = !i_pwr_on_ack;  waiting = 1'b1; end
            ST_PWR_ON:  begin ack_seen = i_pwr_on_ack;   waiting = 1'b1; end
            default:    begin ack_seen = 1'b0;           waiting = 1'b0; end
        endcase
    end

`ifdef PD_SEQ_ACK_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err;

    // The 255th cycle in an ack-wait state is treated as if the ack had arrived.
    assign tmo   = waiting && (tcnt == 8'd254);
    assign o_err = err;

    always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
        if (!i_soc_pwr_on_rst_n) begin
            tcnt <= 8'd0;
            err  <= 1'b0;
        end else begin
            if (state_nx != state) tcnt <= 8'd0;
            else if (waiting)      tcnt <= tcnt + 8'd1;
            if (tmo && !ack_seen)  err  <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign o_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_ON:      if (i_sw_sleep_req && !i_wakeup) state_nx = ST_SLP_REQ;
            ST_SLP_REQ: begin
                if (ack_seen || tmo)                 state_nx = ST_CLK_OFF;
                else if (i_wakeup || !i_sw_sleep_req) state_nx = ST_ON;
            end
            ST_CLK_OFF: if (step_done) state_nx = ST_ISO_ON;
            ST_ISO_ON:  if (step_done) state_nx = ret_flag ? ST_RET_ON : ST_RST_ON;
            ST_RET_ON:  if (step_done) state_nx = ST_RST_ON;
            ST_RST_ON:  if (step_done) state_nx = ST_PWR_OFF;
            ST_PWR_OFF: if (ack_seen || tmo) state_nx = ST_OFF;
            ST_OFF:     if (i_wakeup || wake_pend) state_nx = ST_PWR_ON;
            ST_PWR_ON:  if (ack_seen || tmo) state_nx = ST_RST_OFF;
            ST_RST_OFF: if (step_done) state_nx = ret_flag ? ST_RET_OFF : ST_ISO_OFF;
            ST_RET_OFF: if (step_done) state_nx = ST_ISO_OFF;
            ST_ISO_OFF: if (step_done) state_nx = ST_CLK_ON;
            ST_CLK_ON:  if (step_done) state_nx = ST_ON;
            default:    state_nx = ST_ON;
        endcase
    end

    // Every control output changes only on the edge that enters the state owning it.
    always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
        if (!i_soc_pwr_on_rst_n) begin
            state        <= ST_ON;
            cnt          <= 4'd0;
            wake_pend    <= 1'b0;
            ret_flag     <= 1'b0;
            o_sleep_req  <= 1'b0;
            o_pwr_on_req <= 1'b1;
            o_clk_en     <= 1'b1;
            o_iso        <= 1'b0;
            o_ret        <= 1'b0;
            o_rstn       <= 1'b1;
        end else begin
            state <= state_nx;
            if (state_nx != state) cnt <= 4'd0;
            else if (timed)        cnt <= cnt + 4'd1;
            if (state == ST_ON && state_nx == ST_SLP_REQ) ret_flag <= i_ret_en;
            if (i_wakeup && state >= ST_CLK_OFF && state <= ST_PWR_OFF) wake_pend <= 1'b1;
            if (state_nx != state) begin
                case (state_nx)
                    ST_ON:      o_sleep_req  <= 1'b0;
                    ST_SLP_REQ: o_sleep_req  <= 1'b1;
                    ST_CLK_OFF: o_clk_en     <= 1'b0;
                    ST_ISO_ON:  o_iso        <= 1'b1;
                    ST_RET_ON:  o_ret        <= 1'b1;
                    ST_RST_ON:  o_rstn       <= 1'b0;
                    ST_PWR_OFF: o_pwr_on_req <= 1'b0;
                    ST_PWR_ON: begin
                        o_pwr_on_req <= 1'b1;
                        o_sleep_req  <= 1'b0;
                        wake_pend    <= 1'b0;
                    end
                    ST_RST_OFF: o_rstn       <= 1'b1;
                    ST_RET_OFF: o_ret        <= 1'b0;
                    ST_ISO_OFF: o_iso        <= 1'b0;
                    ST_CLK_ON:  o_clk_en     <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign o_state = state;
    assign o_busy  = (state != ST_ON) && (state != ST_OFF);

endmodule

// File: tb/tb_pd_seq_ctrl.sv
// Bench for pd_seq_ctrl: directed sequences plus random traffic against a step-list reference model.
// Define PD_SEQ_ACK_TIMEOUT_EN for both files to exercise the ack timeout.
module tb_pd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw, wk, hwa, pwa, ret_en;
    logic [3:0] doff, don;
    logic       o_sleep_req, o_pwr_on_req, o_clk_en, o_iso, o_ret, o_rstn;
    logic [3:0] o_state;
    logic       o_busy, o_err;

    pd_seq_ctrl dut (
        .i_aon_clk           (clk),
        .i_soc_pwr_on_rst_n  (rst_n),
        .i_sw_sleep_req      (sw),
        .i_wakeup            (wk),
        .i_hw_sleep_ack      (hwa),
        .i_pwr_on_ack        (pwa),
        .i_pwr_off_seq_delay (doff),
        .i_pwr_on_seq_delay  (don),
        .i_ret_en            (ret_en),
        .o_sleep_req         (o_sleep_req),
        .o_pwr_on_req        (o_pwr_on_req),
        .o_clk_en            (o_clk_en),
        .o_iso               (o_iso),
        .o_ret               (o_ret),
        .o_rstn              (o_rstn),
        .o_state             (o_state),
        .o_busy              (o_busy),
        .o_err               (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_mode = 1;
    int t_chg[4][2];
    logic saw_ret;
    logic [3:0] prev_sig;

    // Reference model: a sequence is a list of (state code, signal, value) steps.
    typedef struct { logic [3:0] code; int sig; logic val; } step_t;
    typedef enum int { P_ON, P_REQ, P_DOWN, P_PDN, P_OFF, P_PUP, P_UP } phase_t;
    step_t  off_tbl[4];
    step_t  on_tbl[4];
    step_t  seq_q[$];
    phase_t ph;
    logic [3:0] m_code;
    logic   m_sig[4];
    logic   m_sleep, m_pwr, m_err, m_pend, m_ret;
    int     m_remain, m_wait;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {4'h0, o_state, o_busy, o_err, o_sleep_req, o_pwr_on_req,
                o_clk_en, o_iso, o_ret, o_rstn};
    endfunction

    function automatic logic [3:0] m_state_code();
        case (ph)
            P_ON:    return 4'd0;
            P_REQ:   return 4'd1;
            P_PDN:   return 4'd6;
            P_OFF:   return 4'd7;
            P_PUP:   return 4'd8;
            default: return m_code;
        endcase
    endfunction

    function automatic logic [15:0] model_vec();
        logic [3:0] s;
        logic busy;
        s    = m_state_code();
        busy = (s != 4'd0) && (s != 4'd7);
        return {4'h0, s, busy, m_err, m_sleep, m_pwr, m_sig[0], m_sig[1], m_sig[2], m_sig[3]};
    endfunction

    task automatic model_reset();
        ph = P_ON; m_code = 4'd0;
        m_sig[0] = 1'b1; m_sig[1] = 1'b0; m_sig[2] = 1'b0; m_sig[3] = 1'b1;
        m_sleep = 1'b0; m_pwr = 1'b1; m_err = 1'b0; m_pend = 1'b0; m_ret = 1'b0;
        m_remain = 0; m_wait = 0;
        seq_q.delete();
    endtask

    task automatic load_seq(input logic down);
        seq_q.delete();
        for (int i = 0; i < 4; i++) begin
            step_t s;
            s = down ? off_tbl[i] : on_tbl[i];
            if (s.sig != 2 || m_ret) seq_q.push_back(s);
        end
    endtask

    task automatic start_step(input logic [3:0] d);
        step_t s;
        s = seq_q.pop_front();
        m_code = s.code;
        m_sig[s.sig] = s.val;
        m_remain = (d == 4'd0) ? 1 : int'(d);
    endtask

    task automatic model_edge();
        logic tmo;
        tmo = 1'b0;
`ifdef PD_SEQ_ACK_TIMEOUT_EN
        tmo = (m_wait == 254);
`endif
        case (ph)
            P_ON: if (sw && !wk) begin
                ph = P_REQ; m_sleep = 1'b1; m_ret = ret_en; m_wait = 0;
            end
            P_REQ: begin
                if (hwa || tmo) begin
                    if (!hwa) m_err = 1'b1;
                    load_seq(1'b1); ph = P_DOWN; start_step(doff);
                end else if (wk || !sw) begin
                    ph = P_ON; m_sleep = 1'b0;
                end else m_wait++;
            end
            P_DOWN: begin
                if (wk) m_pend = 1'b1;
                m_remain--;
                if (m_remain == 0) begin
                    if (seq_q.size() == 0) begin ph = P_PDN; m_pwr = 1'b0; m_wait = 0; end
                    else start_step(doff);
                end
            end
            P_PDN: begin
                if (wk) m_pend = 1'b1;
                if (!pwa || tmo) begin
                    if (pwa) m_err = 1'b1;
                    ph = P_OFF;
                end else m_wait++;
            end
            P_OFF: if (wk || m_pend) begin
                ph = P_PUP; m_pwr = 1'b1; m_sleep = 1'b0; m_pend = 1'b0; m_wait = 0;
            end
            P_PUP: begin
                if (pwa || tmo) begin
                    if (!pwa) m_err = 1'b1;
                    load_seq(1'b0); ph = P_UP; start_step(don);
                end else m_wait++;
            end
            default: begin
                m_remain--;
                if (m_remain == 0) begin
                    if (seq_q.size() == 0) ph = P_ON;
                    else start_step(don);
                end
            end
        endcase
    endtask

    task automatic clear_times();
        for (int i = 0; i < 4; i++) begin t_chg[i][0] = -1; t_chg[i][1] = -1; end
        saw_ret  = 1'b0;
        prev_sig = {o_rstn, o_ret, o_iso, o_clk_en};
    endtask

    // Called at a falling edge; returns at the next falling edge after one checked cycle.
    task automatic tick();
        logic [3:0] cur;
        if (ack_mode == 1) pwa = m_pwr;
        else if (ack_mode == 2 && pwa != m_pwr && $urandom_range(0, 1) == 1) pwa = m_pwr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("cyc", dut_vec(), model_vec());
        if (o_state == 4'd4 || o_state == 4'd10 || o_ret) saw_ret = 1'b1;
        cur = {o_rstn, o_ret, o_iso, o_clk_en};
        for (int i = 0; i < 4; i++)
            if (cur[i] != prev_sig[i]) t_chg[i][int'(cur[i])] = cyc;
        prev_sig = cur;
    endtask

    task automatic run_until(input logic [3:0] code, input int budget);
        int n;
        n = 0;
        while (o_state !== code && n < budget) begin tick(); n++; end
        check($sformatf("reach_%0d", code), 16'(o_state), 16'(code));
    endtask

    task automatic go_down(input logic [3:0] d_off, input logic [3:0] d_on, input logic r);
        doff = d_off; don = d_on; ret_en = r; wk = 1'b0;
        clear_times();
        sw = 1'b1; hwa = 1'b0; tick();
        hwa = 1'b1; tick();
        sw = 1'b0; hwa = 1'b0;
    endtask

    initial begin
        logic [15:0] rst_vec;
        int n;
        rst_vec = {4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        off_tbl[0] = '{4'd2, 0, 1'b0};  off_tbl[1] = '{4'd3, 1, 1'b1};
        off_tbl[2] = '{4'd4, 2, 1'b1};  off_tbl[3] = '{4'd5, 3, 1'b0};
        on_tbl[0]  = '{4'd9, 3, 1'b1};  on_tbl[1]  = '{4'd10, 2, 1'b0};
        on_tbl[2]  = '{4'd11, 1, 1'b0}; on_tbl[3]  = '{4'd12, 0, 1'b1};
        rst_n = 1'b0; sw = 1'b0; wk = 1'b0; hwa = 1'b0; pwa = 1'b1; ret_en = 1'b0;
        doff = 4'd0; don = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset", dut_vec(), rst_vec);
        rst_n = 1'b1;

        // Full retention cycle, off delay 2, on delay 3
        go_down(4'd2, 4'd3, 1'b1);
        run_until(4'd7, 60);
        wk = 1'b1; tick(); wk = 1'b0;
        run_until(4'd0, 60);
        check("off_clk_iso",  16'(t_chg[1][1] - t_chg[0][0]), 16'd2);
        check("off_iso_ret",  16'(t_chg[2][1] - t_chg[1][1]), 16'd2);
        check("off_ret_rst",  16'(t_chg[3][0] - t_chg[2][1]), 16'd2);
        check("on_rst_ret",   16'(t_chg[2][0] - t_chg[3][1]), 16'd3);
        check("on_ret_iso",   16'(t_chg[1][0] - t_chg[2][0]), 16'd3);
        check("on_iso_clk",   16'(t_chg[0][1] - t_chg[1][0]), 16'd3);

        // Zero delays, no retention
        go_down(4'd0, 4'd0, 1'b0);
        run_until(4'd7, 60);
        wk = 1'b1; tick(); wk = 1'b0;
        run_until(4'd0, 60);
        check("noret_seen",    16'(saw_ret), 16'd0);
        check("d0_clk_iso",    16'(t_chg[1][1] - t_chg[0][0]), 16'd1);
        check("d0_iso_rst",    16'(t_chg[3][0] - t_chg[1][1]), 16'd1);
        check("d0_rst_iso",    16'(t_chg[1][0] - t_chg[3][1]), 16'd1);
        check("d0_iso_clk",    16'(t_chg[0][1] - t_chg[1][0]), 16'd1);

        // Wakeup abort while waiting for the sleep ack
        doff = 4'd1; don = 4'd1; ret_en = 1'b1; hwa = 1'b0;
        sw = 1'b1; tick(); tick();
        wk = 1'b1; tick();
        check("abort", 16'({o_sleep_req, o_clk_en, o_state}), 16'({1'b0, 1'b1, 4'd0}));
        wk = 1'b0; sw = 1'b0; tick();

        // One-cycle wakeup during ISO_ON becomes a pending wake
        go_down(4'd1, 4'd1, 1'b1);
        tick();
        check("in_iso_on", 16'(o_state), 16'd3);
        wk = 1'b1; tick(); wk = 1'b0;
        run_until(4'd7, 40);
        tick();
        check("off_hold", 16'(o_state), 16'd8);
        run_until(4'd0, 40);

        // Asynchronous reset in the middle of RST_ON
        go_down(4'd3, 4'd1, 1'b1);
        run_until(4'd5, 60);
        #2 rst_n = 1'b0;
        #1 check("rst_async", dut_vec(), rst_vec);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_times();

        // Random traffic
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            sw     = ($urandom_range(0, 3) != 0);
            wk     = ($urandom_range(0, 9) == 0);
            hwa    = ($urandom_range(0, 2) == 0);
            ret_en = 1'($urandom_range(0, 1));
            if (ph == P_ON) begin
                doff = 4'($urandom_range(0, 4));
                don  = 4'($urandom_range(0, 4));
            end
            tick();
        end
        sw = 1'b0; hwa = 1'b0; wk = 1'b1;
        run_until(4'd0, 400);
        wk = 1'b0;

`ifdef PD_SEQ_ACK_TIMEOUT_EN
        ack_mode = 0; pwa = 1'b1;
        go_down(4'd0, 4'd0, 1'b0);
        run_until(4'd6, 20);
        n = 0;
        while (!o_err && n < 400) begin tick(); n++; end
        check("tmo_cycles", 16'(n), 16'd255);
        check("tmo_state", 16'(o_state), 16'd7);
        wk = 1'b1; tick(); wk = 1'b0;
        run_until(4'd0, 40);
`else
        n = 0;
        check("err_tied", 16'(o_err), 16'(n));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
